control_seq: RTL

- Sequential successor to the combinational CPU control decoder.
- Owns the instruction register, the multi-cycle counter (previously an external `cycle` input), the carry flag and the interrupt-enable flag. Adds a fetch handshake and memory-wait stalls.
- Sits between the fetch unit and the datapath. Strobes are decoded from the latched IR and the internal cycle count, and are registered-state-driven: no combinational path from `inst` to any strobe.

---
 rtl/control_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// Sequential CPU control unit: latches instructions from fetch, steps multi-cycle
// instructions, stalls on memory, and owns the carry and interrupt-enable flags.
module control_seq #(
    parameter int IW       = 8,
    parameter int LONG_CYC = 2,
    parameter int CW       = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inst,
    input  logic          inst_valid,
    output logic          inst_ready,
    input  logic          mem_ready,
    input  logic          carry_in,
    input  logic          irq,
    output logic          irq_ack,
    output logic          ie,
    output logic          carry_q,
    output logic [CW-1:0] cycle,
    output logic          retire,
    output logic          M,
    output logic          MW,
    output logic          MC,
    output logic          J,
    output logic          LJ,
    output logic          CLI,
    output logic          LJR,
    output logic          RD,
    output logic          WR,
    output logic          WA,
    output logic          WC,
    output logic          ISP,
    output logic          S,
    output logic          Y,
    output logic [1:0]    RS,
    output logic [3:0]    ALU
);

    // Fetch handshake: an instruction transfers on a cycle where inst_valid and
    // inst_ready are both high; inst_ready is high when idle or when the current
    // instruction retires, so back-to-back instructions lose no cycle.
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ir_q, ir_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic          carry_d;
    logic          ie_q, ie_d;

    logic          exec, last, stall, accept, ie_post;
    logic          simple, lj_raw, isalu;
    logic [CW-1:0] ncyc_m1;
    logic          unused_inst;

    assign unused_inst = ^inst;

    assign exec    = (state_q == EXEC);
    assign ncyc_m1 = ir_q[7] ? CW'(LONG_CYC - 1) : '0;
    assign last    = (cycle_q == ncyc_m1);

    // Strobes are decoded from IR and cycle only, never from the inst input.
    assign simple = (ir_q[7:5] == 3'b000);
    assign lj_raw = simple & ir_q[4] & ~ir_q[3];
    assign isalu  = (ir_q[7:6] == 2'b01) | ((ir_q[7:5] == 3'b110) & last);

    assign LJ  = exec & lj_raw;
    assign CLI = exec & lj_raw & ir_q[1];
    assign LJR = exec & lj_raw & ir_q[2];
    assign RD  = exec & simple & ~ir_q[4] & ir_q[2];
    assign WR  = exec & simple & ~ir_q[4] & ir_q[3];
    assign MC  = exec & ir_q[7] & (cycle_q == '0);
    assign M   = exec & (ir_q[7:6] == 2'b10) & last;
    assign MW  = M & ir_q[5];
    assign J   = exec & (ir_q[7:5] == 3'b111) & last & ~(ir_q[4] & carry_q);
    assign ISP = exec & (ir_q[7:5] == 3'b001);
    assign WA  = (M & ~ir_q[5]) | (exec & isalu & ~(ir_q[4] & ~ir_q[3]));
    assign WC  = exec & ir_q[4] & (isalu | (ir_q[7:5] == 3'b001));
    assign ALU = exec ? {(ir_q[6] ? ir_q[3] : ~ir_q[7]), ir_q[2:0] & {3{ir_q[6]}}} : 4'h0;
    assign S   = ir_q[4];
    assign Y   = ir_q[5];
    assign RS  = ir_q[1:0];

    assign stall      = M & ~mem_ready;
    assign retire     = exec & last & ~stall;
    assign inst_ready = ~exec | retire;
    assign accept     = inst_valid & inst_ready;

    // A retiring CLI clears ie before the interrupt check, so it blocks the ack.
    assign ie_post = CLI ? 1'b0 : (LJR ? 1'b1 : ie_q);
    assign irq_ack = retire & ie_post & irq;

    assign ie    = ie_q;
    assign cycle = cycle_q;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cycle_d = cycle_q;
        carry_d = carry_q;
        ie_d    = ie_q;
        if (retire) begin
            if (WC) carry_d = carry_in;
            ie_d = irq_ack ? 1'b0 : ie_post;
        end
        if (accept) begin
            state_d = EXEC;
            ir_d    = inst[7:0];
            cycle_d = '0;
        end else if (exec) begin
            if (retire) begin
                state_d = IDLE;
                cycle_d = '0;
            end else if (!last && !stall) begin
                cycle_d = cycle_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= 8'h00;
            cycle_q <= '0;
            carry_q <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cycle_q <= cycle_d;
            carry_q <= carry_d;
            ie_q    <= ie_d;
        end
    end

endmodule
